// File: rtl/id_skid_stage.sv
// Two-entry fetch-to-decode skid stage: strict FIFO order, 1-cycle accept-to-output latency, NOP bubble when empty.
// in_ready depends only on registered state, so upstream never sees a combinational path from out_ready.
module id_skid_stage #(
  parameter int           W     = 32,
  parameter int           NSIDE = 2,
  parameter logic [W-1:0] NOP   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_inst,
  input  logic [NSIDE*W-1:0]   in_side,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_inst,
  output logic [NSIDE*W-1:0]   out_side,
  output logic [1:0]           occupancy,
  output logic [15:0]          stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [W-1:0]         main_inst;
  logic [W-1:0]         skid_inst;
  logic [NSIDE*W-1:0]   main_side;
  logic [NSIDE*W-1:0]   skid_side;
  logic                 accept;
  logic                 consume;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Bubble injection: stale register contents never leak to decode.
  assign out_inst  = out_valid ? main_inst : NOP;
  assign out_side  = out_valid ? main_side : '0;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_inst <= '0;
      main_side <= '0;
      skid_inst <= '0;
      skid_side <= '0;
    end else begin
      if (load_main_in) begin
        main_inst <= in_inst;
        main_side <= in_side;
      end else if (load_main_skid) begin
        main_inst <= skid_inst;
        main_side <= skid_side;
      end
      if (load_skid) begin
        skid_inst <= in_inst;
        skid_side <= in_side;
      end
    end
  end

  // Counts every blocked upstream cycle, flush or not; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_skid_stage.sv
// Directed bench for id_skid_stage: a default 32-bit instance and a 16-bit, 3-sideband instance with a non-zero NOP.
module tb_id_skid_stage;

  logic        clk;
  logic        reset;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_inst, a_out_inst;
  logic [63:0] a_in_side, a_out_side;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [15:0] b_in_inst, b_out_inst;
  logic [47:0] b_in_side, b_out_side;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  int n_cmp;
  int n_err;

  id_skid_stage u0 (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_side(a_in_side),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inst(a_out_inst), .out_side(a_out_side),
    .occupancy(a_occ), .stall_count(a_stall)
  );

  id_skid_stage #(.W(16), .NSIDE(3), .NOP(16'h0013)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_side(b_in_side),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst), .out_side(b_out_side),
    .occupancy(b_occ), .stall_count(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    a_in_valid = 0; a_in_inst = '0; a_in_side = '0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_inst = '0; b_in_side = '0; b_flush = 0; b_out_ready = 0;

    // Reset state before any clock edge
    #3;
    chk("rst_occ",      64'(a_occ),       64'd0);
    chk("rst_valid",    64'(a_out_valid), 64'd0);
    chk("rst_inst",     64'(a_out_inst),  64'd0);
    chk("rst_side",     64'(a_out_side),  64'd0);
    chk("rst_stall",    64'(a_stall),     64'd0);
    chk("rst_in_ready", 64'(a_in_ready),  64'd1);
    chk("rst_nop_b",    64'(b_out_inst),  64'h0013);
    tick();
    tick();
    reset = 1'b0;

    // Single accept, 1-cycle latency
    a_in_inst = 32'h2002_0005; a_in_side = 64'h0000_00A1_0000_00A0; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    chk("lat_valid",    64'(a_out_valid), 64'd1);
    chk("lat_inst",     64'(a_out_inst),  64'h2002_0005);
    chk("lat_side",     64'(a_out_side),  64'h0000_00A1_0000_00A0);
    chk("lat_occ",      64'(a_occ),       64'd1);
    chk("lat_in_ready", 64'(a_in_ready),  64'd1);
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    chk("drain_occ",  64'(a_occ),       64'd0);
    chk("drain_inst", 64'(a_out_inst),  64'd0);
    chk("drain_side", 64'(a_out_side),  64'd0);

    // Fill to FULL, block C for three cycles, then drain in order
    a_in_valid = 1;
    a_in_inst = 32'h11; a_in_side = 64'h0000_1101_0000_1100;
    tick();
    a_in_inst = 32'h22; a_in_side = 64'h0000_2201_0000_2200;
    tick();
    a_in_inst = 32'h33; a_in_side = 64'h0000_3301_0000_3300;
    tick();
    tick();
    tick();
    chk("full_occ",      64'(a_occ),      64'd2);
    chk("full_in_ready", 64'(a_in_ready), 64'd0);
    chk("full_stall",    64'(a_stall),    64'd3);
    chk("full_head",     64'(a_out_inst), 64'h11);
    a_out_ready = 1;
    tick();
    // C still blocked on this edge, so one more stall is counted
    chk("ord_b_inst",  64'(a_out_inst), 64'h22);
    chk("ord_b_side",  64'(a_out_side), 64'h0000_2201_0000_2200);
    chk("ord_b_occ",   64'(a_occ),      64'd1);
    chk("ord_b_stall", 64'(a_stall),    64'd4);
    tick();
    a_in_valid = 0;
    chk("ord_c_inst", 64'(a_out_inst), 64'h33);
    chk("ord_c_occ",  64'(a_occ),      64'd1);
    tick();
    a_out_ready = 0;
    chk("ord_empty", 64'(a_occ), 64'd0);

    // Simultaneous accept and consume in ONE
    a_in_valid = 1; a_in_inst = 32'h44; a_in_side = 64'h44;
    tick();
    a_in_inst = 32'h55; a_in_side = 64'h55; a_out_ready = 1;
    tick();
    a_in_valid = 0;
    chk("pass_inst", 64'(a_out_inst), 64'h55);
    chk("pass_occ",  64'(a_occ),      64'd1);
    tick();
    a_out_ready = 0;
    chk("pass_empty", 64'(a_occ), 64'd0);

    // Flush from FULL with a blocked upstream and a same-cycle consume
    a_in_valid = 1;
    a_in_inst = 32'h66; a_in_side = 64'h66;
    tick();
    a_in_inst = 32'h77; a_in_side = 64'h77;
    tick();
    chk("fl_pre_occ", 64'(a_occ), 64'd2);
    a_in_inst = 32'h88; a_flush = 1; a_out_ready = 1;
    #1;
    chk("fl_consume_valid", 64'(a_out_valid), 64'd1);
    chk("fl_consume_inst",  64'(a_out_inst),  64'h66);
    tick();
    a_flush = 0; a_out_ready = 0; a_in_valid = 0;
    chk("fl_occ",      64'(a_occ),       64'd0);
    chk("fl_valid",    64'(a_out_valid), 64'd0);
    chk("fl_inst",     64'(a_out_inst),  64'd0);
    chk("fl_side",     64'(a_out_side),  64'd0);
    chk("fl_in_ready", 64'(a_in_ready),  64'd1);
    chk("fl_stall",    64'(a_stall),     64'd5);

    // Flush in ONE discards the entry accepted in the same cycle
    a_in_valid = 1; a_in_inst = 32'h99; a_in_side = 64'h99;
    tick();
    a_in_inst = 32'hAA; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl1_occ", 64'(a_occ), 64'd0);
    tick();
    chk("fl1_still_empty", 64'(a_out_valid), 64'd0);
    chk("fl1_stall",       64'(a_stall),     64'd5);

    // Wide sideband through main and skid on the 16-bit instance
    b_in_valid = 1; b_in_inst = 16'h1234; b_in_side = {16'h000C, 16'h0008, 16'h0004};
    tick();
    chk("b_side_main", 64'(b_out_side), 64'h0000_000C_0008_0004);
    chk("b_inst_main", 64'(b_out_inst), 64'h1234);
    chk("b_occ1",      64'(b_occ),      64'd1);
    b_in_inst = 16'h5678; b_in_side = {16'h0001, 16'h0002, 16'h0003};
    tick();
    b_in_valid = 0; b_out_ready = 1;
    chk("b_occ2", 64'(b_occ), 64'd2);
    tick();
    b_out_ready = 0;
    chk("b_side_skid", 64'(b_out_side), 64'h0000_0001_0002_0003);
    chk("b_inst_skid", 64'(b_out_inst), 64'h5678);
    b_in_valid = 1; b_in_inst = 16'h9ABC; b_in_side = 48'h0;
    tick();
    b_in_valid = 0;
    chk("b_refull", 64'(b_occ), 64'd2);

    // Asynchronous reset mid-FULL, checked well before the next edge
    #2;
    reset = 1'b1;
    #1;
    chk("ar_occ",      64'(b_occ),       64'd0);
    chk("ar_valid",    64'(b_out_valid), 64'd0);
    chk("ar_inst",     64'(b_out_inst),  64'h0013);
    chk("ar_side",     64'(b_out_side),  64'd0);
    chk("ar_in_ready", 64'(b_in_ready),  64'd1);
    chk("ar_a_stall",  64'(a_stall),     64'd0);
    #1;
    reset = 1'b0;
    tick();
    b_in_valid = 1; b_in_inst = 16'hDEAD; b_in_side = 48'h0000_0000_0007;
    tick();
    b_in_valid = 0;
    chk("post_rst_valid", 64'(b_out_valid), 64'd1);
    chk("post_rst_inst",  64'(b_out_inst),  64'hDEAD);

    // Stall counter saturation
    a_in_valid = 1; a_in_inst = 32'h1; a_in_side = 64'h0;
    tick();
    tick();
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 64'(a_stall), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(a_stall), 64'hFFFF);
    tick();
    tick();
    chk("sat_hold", 64'(a_stall), 64'hFFFF);
    a_in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
